// File: rtl/pulse_period_meter.sv
// Measures the rising-edge period of a (possibly asynchronous) square wave in clk cycles,
// checks it against EXPECTED +/- TOL, and reports lock and edge-loss timeout.
module pulse_period_meter #(
   parameter  int EXPECTED = 200_000,
   parameter  int TOL      = 16,
   parameter  int TIMEOUT  = 800_000,
   parameter  int LOCK_N   = 4,
   localparam int W        = $clog2(TIMEOUT + 1)
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_pulse_in,
   output logic [W-1:0] o_period,
   output logic         o_period_valid,
   output logic         o_in_range,
   output logic         o_locked,
   output logic         o_timeout
);

   localparam int GW     = $clog2(LOCK_N + 1);
   localparam int LO_INT = (TOL > EXPECTED) ? 0 : (EXPECTED - TOL);

   localparam logic [W-1:0]  CNT_MAX  = W'(TIMEOUT);
   localparam logic [W-1:0]  LO_W     = W'(LO_INT);
   localparam logic [W-1:0]  HI_W     = W'(EXPECTED + TOL);
   localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_N);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_TOUT    = 2'd2
   } state_t;

   // r_sync[0]/[1] form the synchronizer, r_sync[2] is the edge-detect delay stage
   logic [2:0]    r_sync;
   logic          r_rise;

   state_t        r_state;
   state_t        w_state_next;
   logic [W-1:0]  r_cnt;
   logic [W-1:0]  w_cnt_next;
   logic [W-1:0]  r_period;
   logic [W-1:0]  w_period_next;
   logic          r_period_valid;
   logic          w_period_valid_next;
   logic          r_in_range;
   logic          w_in_range_next;
   logic [GW-1:0] r_good;
   logic [GW-1:0] w_good_next;
   logic          r_locked;
   logic          w_locked_next;
   logic          r_timeout;
   logic          w_timeout_next;
   logic          w_in_window;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_sync <= '0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[1:0], i_pulse_in};
         r_rise <= r_sync[1] & ~r_sync[2];
      end
   end

   assign w_in_window = (r_cnt >= LO_W) && (r_cnt <= HI_W);

   always_comb begin
      w_state_next        = r_state;
      w_cnt_next          = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + W'(1));
      w_period_next       = r_period;
      w_period_valid_next = 1'b0;
      w_in_range_next     = r_in_range;
      w_good_next         = r_good;
      w_locked_next       = r_locked;
      w_timeout_next      = r_timeout;

      if (r_rise) begin
         w_cnt_next = W'(1);
      end

      case (r_state)
         ST_IDLE: begin
            if (r_rise) begin
               w_state_next = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            // A rise coinciding with the saturation point is still a valid period
            if (r_rise) begin
               w_period_next       = r_cnt;
               w_period_valid_next = 1'b1;
               w_in_range_next     = w_in_window;
               if (w_in_window) begin
                  w_good_next = (r_good == GOOD_MAX) ? r_good : (r_good + GW'(1));
               end else begin
                  w_good_next = '0;
               end
               w_locked_next = (w_good_next == GOOD_MAX);
            end else if (r_cnt == CNT_MAX) begin
               w_state_next   = ST_TOUT;
               w_timeout_next = 1'b1;
               w_good_next    = '0;
               w_locked_next  = 1'b0;
            end
         end
         ST_TOUT: begin
            w_timeout_next = 1'b1;
            w_good_next    = '0;
            w_locked_next  = 1'b0;
            // The edge ending a timeout only re-arms; the gap is not a period
            if (r_rise) begin
               w_state_next   = ST_MEASURE;
               w_timeout_next = 1'b0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_in_range     <= 1'b0;
         r_good         <= '0;
         r_locked       <= 1'b0;
         r_timeout      <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_cnt          <= w_cnt_next;
         r_period       <= w_period_next;
         r_period_valid <= w_period_valid_next;
         r_in_range     <= w_in_range_next;
         r_good         <= w_good_next;
         r_locked       <= w_locked_next;
         r_timeout      <= w_timeout_next;
      end
   end

   assign o_period       = r_period;
   assign o_period_valid = r_period_valid;
   assign o_in_range     = r_in_range;
   assign o_locked       = r_locked;
   assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: stimulus queues expected strobes, a negedge
// monitor pops and compares them whenever period_valid is seen.
module tb_pulse_period_meter;

   localparam int W = 7;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         pulse_in = 1'b0;
   logic [W-1:0] period;
   logic         period_valid;
   logic         in_range;
   logic         locked;
   logic         timeout;

   typedef struct {
      int p;
      bit inr;
      bit lk;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   strobe_idx = 0;
   bit   saw_tout = 1'b0;

   pulse_period_meter #(
      .EXPECTED(20),
      .TOL(2),
      .TIMEOUT(80),
      .LOCK_N(3)
   ) dut (
      .i_clk(clk),
      .i_rstn(rstn),
      .i_pulse_in(pulse_in),
      .o_period(period),
      .o_period_valid(period_valid),
      .o_in_range(in_range),
      .o_locked(locked),
      .o_timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      saw_tout = saw_tout | timeout;
   endtask

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end else begin
         $display("[TB] check %s = %0d ok", name, act);
      end
   endtask

   // Drive a rise now, then hold the wave for p cycles; the rise closes the previous gap
   task automatic rise_hold(input int p, input bit strobe, input int ep, input bit einr, input bit elk);
      if (strobe) q.push_back(exp_t'{ep, einr, elk});
      pulse_in = 1'b1;
      repeat (p / 2) step();
      pulse_in = 1'b0;
      repeat (p - p / 2) step();
   endtask

   always @(negedge clk) begin
      if (period_valid) begin
         strobe_idx++;
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe #%0d: got period %0d, required no strobe", strobe_idx, period);
         end else begin
            mon_e = q.pop_front();
            if (period !== W'(mon_e.p) || in_range !== mon_e.inr || locked !== mon_e.lk) begin
               fails++;
               $display("FAIL strobe #%0d: got period=%0d in_range=%0b locked=%0b, required period=%0d in_range=%0b locked=%0b",
                        strobe_idx, period, in_range, locked, mon_e.p, mon_e.inr, mon_e.lk);
            end else begin
               $display("[TB] strobe #%0d period=%0d in_range=%0b locked=%0b ok",
                        strobe_idx, period, in_range, locked);
            end
         end
      end
   end

   initial begin
      int nv;

      // 1. reset state, then nominal wave and lock on the third strobe
      rstn = 1'b0;
      pulse_in = 1'b0;
      repeat (5) step();
      chk("reset_period", int'(period), 0);
      chk("reset_valid", int'(period_valid), 0);
      chk("reset_in_range", int'(in_range), 0);
      chk("reset_locked", int'(locked), 0);
      chk("reset_timeout", int'(timeout), 0);
      rstn = 1'b1;
      step();
      rise_hold(20, 1'b0, 0, 1'b0, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b1);

      // 2. one long period breaks lock, three good ones restore it
      rise_hold(25, 1'b1, 20, 1'b1, 1'b1);
      rise_hold(20, 1'b1, 25, 1'b0, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b1);

      // 3. tolerance edges 18, 22, 17, 23
      rise_hold(18, 1'b1, 20, 1'b1, 1'b1);
      rise_hold(22, 1'b1, 18, 1'b1, 1'b1);
      rise_hold(17, 1'b1, 22, 1'b1, 1'b1);
      rise_hold(23, 1'b1, 17, 1'b0, 1'b0);
      rise_hold(20, 1'b1, 23, 1'b0, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b1);

      // 4. last rise, then the wave stops: timeout exactly 80 cycles after the strobe
      q.push_back(exp_t'{20, 1'b1, 1'b1});
      pulse_in = 1'b1;
      nv = -1;
      for (int n = 1; n <= 120; n++) begin
         step();
         if (n == 10) pulse_in = 1'b0;
         if (period_valid && nv < 0) nv = n;
         if (nv >= 0 && n == nv + 79) begin
            chk("timeout_before_80", int'(timeout), 0);
            chk("locked_before_80", int'(locked), 1);
         end
         if (nv >= 0 && n == nv + 80) begin
            chk("timeout_at_80", int'(timeout), 1);
            chk("locked_cleared_at_80", int'(locked), 0);
            break;
         end
      end
      chk("strobe_latency", nv, 4);
      step();
      chk("timeout_sticky", int'(timeout), 1);
      rise_hold(20, 1'b0, 0, 1'b0, 1'b0);
      chk("timeout_cleared_on_rise", int'(timeout), 0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);

      // 5. edge exactly at cnt=80 is measured, not a timeout
      saw_tout = 1'b0;
      rise_hold(80, 1'b1, 20, 1'b1, 1'b0);
      rise_hold(20, 1'b1, 80, 1'b0, 1'b0);
      chk("no_timeout_at_edge_80", int'(saw_tout), 0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b1);

      // 6. reset mid-period while locked
      pulse_in = 1'b1;
      step();
      step();
      chk("locked_before_reset", int'(locked), 1);
      rstn = 1'b0;
      step();
      chk("midreset_period", int'(period), 0);
      chk("midreset_in_range", int'(in_range), 0);
      chk("midreset_locked", int'(locked), 0);
      chk("midreset_timeout", int'(timeout), 0);
      pulse_in = 1'b0;
      repeat (3) step();
      rstn = 1'b1;
      step();
      rise_hold(20, 1'b0, 0, 1'b0, 1'b0);
      rise_hold(20, 1'b1, 20, 1'b1, 1'b0);
      repeat (10) step();
      chk("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
